// File: rtl/julia_mem_ctrl.sv
// julia_mem_ctrl: write-back memory controller for the julia_worker array.
// Round-robin arbitration over worker done lines, one bus write per grant via
// the wr_ready/wr_done handshake, then a one-cycle mc_done pulse to the winner.
// Optional feature macro: PIXEL_CNT_EN adds a 20-bit completed-write counter.
module julia_mem_ctrl #(
  parameter int unsigned NUM_WORKERS = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                   clk_i,
  input  logic                   n_rst_i,
  input  logic [NUM_WORKERS-1:0] jw_done_i,
  input  logic [DATA_W-1:0]      color_in_i [NUM_WORKERS],
  input  logic [ADDR_W-1:0]      addr_in_i  [NUM_WORKERS],
  input  logic                   wr_done_i,
  output logic [NUM_WORKERS-1:0] mc_done_o,
  output logic [NUM_WORKERS-1:0] mc_busy_o,
  output logic [ADDR_W-1:0]      wr_addr_o,
  output logic [DATA_W-1:0]      wr_data_o,
`ifdef PIXEL_CNT_EN
  output logic [19:0]            pixel_cnt_o,
`endif
  output logic                   wr_ready_o
);

  localparam int unsigned IdxW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [NUM_WORKERS-1:0] OneLsb = NUM_WORKERS'(1);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        rr_ptr_q;
  logic [IdxW-1:0]        grant_q;
  logic [IdxW-1:0]        last_q;
  logic                   mask_vld_q;
  logic [NUM_WORKERS-1:0] mc_done_q;
  logic [NUM_WORKERS-1:0] mc_busy_q;
  logic [ADDR_W-1:0]      wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic                   wr_ready_q;
`ifdef PIXEL_CNT_EN
  logic [19:0]            pixel_cnt_q;
`endif

  logic [NUM_WORKERS-1:0] req_masked;
  logic [IdxW-1:0]        scan_idx;
  logic [IdxW-1:0]        grant_idx;
  logic                   grant_vld;

  // Round-robin pick: first requester at or after rr_ptr_q, wrapping. The worker
  // served last still holds its request for one idle cycle, so it is masked then.
  always_comb begin
    req_masked = jw_done_i;
    if (mask_vld_q) begin
      req_masked[last_q] = 1'b0;
    end
    scan_idx  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < NUM_WORKERS; k++) begin
      scan_idx = rr_ptr_q + IdxW'(k);
      if (!grant_vld && req_masked[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Controller FSM with registered outputs: capture at grant, hold through the
  // handshake, pulse mc_done for exactly one cycle in StDone.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      last_q      <= '0;
      mask_vld_q  <= 1'b0;
      mc_done_q   <= '0;
      mc_busy_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_ready_q  <= 1'b0;
`ifdef PIXEL_CNT_EN
      pixel_cnt_q <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          mask_vld_q <= 1'b0;
          if (grant_vld) begin
            state_q    <= StWrite;
            grant_q    <= grant_idx;
            wr_addr_q  <= addr_in_i[grant_idx];
            wr_data_q  <= color_in_i[grant_idx];
            wr_ready_q <= 1'b1;
            mc_busy_q  <= ~(OneLsb << grant_idx);
          end
        end
        StWrite: begin
          // Address/data stay frozen here; only wr_done advances the write.
          if (wr_done_i) begin
            state_q     <= StDone;
            wr_ready_q  <= 1'b0;
            mc_done_q   <= OneLsb << grant_q;
            rr_ptr_q    <= grant_q + IdxW'(1);
`ifdef PIXEL_CNT_EN
            pixel_cnt_q <= pixel_cnt_q + 20'd1;
`endif
          end
        end
        StDone: begin
          state_q    <= StIdle;
          mc_done_q  <= '0;
          mc_busy_q  <= '0;
          mask_vld_q <= 1'b1;
          last_q     <= grant_q;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mc_done_o   = mc_done_q;
  assign mc_busy_o   = mc_busy_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_ready_o  = wr_ready_q;
`ifdef PIXEL_CNT_EN
  assign pixel_cnt_o = pixel_cnt_q;
`endif

endmodule

// File: tb/tb_julia_mem_ctrl.sv
// Bench for julia_mem_ctrl: directed scenarios plus randomized worker traffic,
// all checked against a cycle-level behavioural model of the controller.
module tb_julia_mem_ctrl;

  localparam int unsigned NW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [NW-1:0] jw_done;
  logic [DW-1:0] color_in [NW];
  logic [AW-1:0] addr_in  [NW];
  logic          wr_done;
  logic [NW-1:0] mc_done;
  logic [NW-1:0] mc_busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
`ifdef PIXEL_CNT_EN
  logic [19:0]   pixel_cnt;
`endif

  julia_mem_ctrl #(
    .NUM_WORKERS(NW),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk_i      (clk),
    .n_rst_i    (n_rst),
    .jw_done_i  (jw_done),
    .color_in_i (color_in),
    .addr_in_i  (addr_in),
    .wr_done_i  (wr_done),
    .mc_done_o  (mc_done),
    .mc_busy_o  (mc_busy),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
`ifdef PIXEL_CNT_EN
    .pixel_cnt_o(pixel_cnt),
`endif
    .wr_ready_o (wr_ready)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 write pending, 2 completion pulse.
  int            m_phase, m_g, m_ptr, m_last, m_cnt;
  bit            m_mask;
  logic          e_ready;
  logic [NW-1:0] e_done, e_busy, m_req;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            m_found;

  int  drop_cnt [NW];
  bit  auto_rel;
  int  grants[$];

  // Compare this cycle's outputs with the model, then advance the model on
  // this cycle's inputs (stable from just after the posedge to the next one).
  always @(negedge clk) begin
    if (!n_rst) begin
      check_eq("rst_wr_ready", wr_ready, 1'b0);
      check_eq("rst_mc_done", mc_done, '0);
      check_eq("rst_mc_busy", mc_busy, '0);
      check_eq("rst_wr_addr", wr_addr, '0);
      check_eq("rst_wr_data", wr_data, '0);
      m_phase = 0; m_ptr = 0; m_mask = 0; m_last = 0; m_g = 0; m_cnt = 0;
      e_ready = 0; e_done = '0; e_busy = '0;
    end else begin
      check_eq("wr_ready", wr_ready, e_ready);
      check_eq("mc_done", mc_done, e_done);
      check_eq("mc_busy", mc_busy, e_busy);
      if (e_ready) begin
        check_eq("wr_addr", wr_addr, e_addr);
        check_eq("wr_data", wr_data, e_data);
      end
`ifdef PIXEL_CNT_EN
      check_eq("pixel_cnt", pixel_cnt, m_cnt);
`endif
      for (int i = 0; i < NW; i++) begin
        if (mc_done[i]) begin
          grants.push_back(i);
          if (auto_rel) drop_cnt[i] = 2;
        end
      end
      case (m_phase)
        0: begin
          m_req = jw_done;
          if (m_mask) m_req[m_last] = 1'b0;
          m_mask  = 0;
          m_found = -1;
          for (int k = 0; k < NW; k++) begin
            if (m_found < 0 && m_req[(m_ptr + k) % NW]) m_found = (m_ptr + k) % NW;
          end
          if (m_found >= 0) begin
            m_phase = 1;
            m_g     = m_found;
            e_ready = 1;
            e_addr  = addr_in[m_g];
            e_data  = color_in[m_g];
            e_busy  = '1;
            e_busy[m_g] = 1'b0;
          end
        end
        1: begin
          if (wr_done) begin
            m_phase = 2;
            e_ready = 0;
            e_done  = '0;
            e_done[m_g] = 1'b1;
            m_ptr   = (m_g + 1) % NW;
            m_cnt   = (m_cnt + 1) % (1 << 20);
          end
        end
        default: begin
          m_phase = 0;
          e_done  = '0;
          e_busy  = '0;
          m_mask  = 1;
          m_last  = m_g;
        end
      endcase
    end
  end

  // Advance one cycle; workers drop jw_done one cycle after seeing mc_done.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) begin
      if (drop_cnt[i] > 0) begin
        drop_cnt[i]--;
        if (drop_cnt[i] == 0) jw_done[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    n_rst   = 1'b0;
    jw_done = '0;
    wr_done = 1'b0;
    for (int i = 0; i < NW; i++) drop_cnt[i] = 0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, wr_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst    = 1'b0;
    jw_done  = '0;
    wr_done  = 1'b0;
    auto_rel = 1'b1;
    for (int i = 0; i < NW; i++) begin
      addr_in[i]  = '0;
      color_in[i] = '0;
      drop_cnt[i] = 0;
    end
    do_reset();

    // Single request, wr_done one cycle after wr_ready.
    addr_in[0]  = 32'h100;
    color_in[0] = 32'hFF00FF00;
    jw_done     = 16'h0001;
    tick();
    check_eq("t1_ready", wr_ready, 1'b1);
    check_eq("t1_addr", wr_addr, 32'h100);
    check_eq("t1_data", wr_data, 32'hFF00FF00);
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check_eq("t1_mc_done", mc_done, 16'h0001);
    tick();
    check_eq("t1_mc_done_clr", mc_done, 16'h0000);
    repeat (3) tick();

    // All workers held high with instant wr_done: strict rotation 0..15,0.
    do_reset();
    auto_rel = 1'b0;
    grants.delete();
    jw_done = '1;
    wr_done = 1'b1;
    for (int n = 0; n < 80 && grants.size() < 17; n++) tick();
    jw_done = '0;
    wr_done = 1'b0;
    check_eq("t2_count", grants.size(), 17);
    for (int k = 0; k < 17 && k < grants.size(); k++) check_eq("t2_order", grants[k], k % 16);
    auto_rel = 1'b1;
    repeat (3) tick();

    // Long stall on worker 3 with addr/color churn and an early request drop.
    addr_in[3]  = 32'h333;
    color_in[3] = 32'h3333_3333;
    jw_done     = 16'h0008;
    wait_ready("t3_grant");
    for (int n = 0; n < 50; n++) begin
      addr_in[3]  = $urandom;
      color_in[3] = $urandom;
      if (n == 20) jw_done[3] = 1'b0;
      tick();
      check_eq("t3_ready", wr_ready, 1'b1);
      check_eq("t3_addr", wr_addr, 32'h333);
    end
    check_eq("t3_busy", mc_busy, 16'hFFF7);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    check_eq("t3_mc_done", mc_done, 16'h0008);
    repeat (3) tick();

    // Worker 15 then worker 0: pointer wraps.
    do_reset();
    jw_done = 16'h8000;
    wait_ready("t4_grant15");
    check_eq("t4_busy15", mc_busy, 16'h7FFF);
    jw_done[0] = 1'b1;
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    wait_ready("t4_grant0");
    check_eq("t4_busy0", mc_busy, 16'hFFFE);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a write, then re-arbitrate from pointer 0.
    jw_done = 16'h0004;
    wait_ready("t5_grant2");
    n_rst = 1'b0;
    #1;
    check_eq("t5_rst_ready", wr_ready, 1'b0);
    check_eq("t5_rst_done", mc_done, 16'h0000);
    jw_done = 16'h0010;
    addr_in[4] = 32'h444;
    for (int i = 0; i < NW; i++) drop_cnt[i] = 0;
    tick();
    n_rst = 1'b1;
    wait_ready("t5_grant4");
    check_eq("t5_busy", mc_busy, 16'hFFEF);
    check_eq("t5_addr", wr_addr, 32'h444);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    repeat (3) tick();

    // Five writes with stray wr_done pulses while idle.
    do_reset();
    for (int w = 0; w < 5; w++) begin
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      check_eq("t6_stray_idle", wr_ready, 1'b0);
      jw_done[w * 3] = 1'b1;
      wait_ready("t6_grant");
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      repeat (3) tick();
    end
`ifdef PIXEL_CNT_EN
    check_eq("t6_pixel_cnt", pixel_cnt, 20'd5);
`endif

    // Random traffic.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NW; i++) begin
        if (!jw_done[i] && drop_cnt[i] == 0 && $urandom_range(0, 7) == 0) begin
          jw_done[i] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
          addr_in[i]  = $urandom;
          color_in[i] = $urandom;
        end
      end
      wr_done = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Drain: every raised request must eventually be served.
    wr_done = 1'b1;
    for (int n = 0; n < 200 && jw_done != '0; n++) tick();
    check_eq("drain_all_served", jw_done, 16'h0000);
    wr_done = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
